// File: rtl/apb_req_arbiter.sv
// APB master shared by NUM_REQ local requesters.
// Round-robin grant, one SETUP/ACCESS transfer per grant, and a one-cycle
// completion pulse to the owner. The slave has no PREADY and registers PRDATA
// on the ACCESS edge, so read data is picked up one cycle later, in RESP.
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_write;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_accept;
  logic               w_write;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx[PTR_W-1:0];
      end
    end
  end

  assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
  // Reset gating keeps req_ready low while PRESET is held, like every other output.
  assign w_accept  = (r_state == S_IDLE) && w_found && !PRESET;
  assign w_write   = req_write[w_win];
  assign w_addr    = req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_wdata   = req_wdata[w_win*DATA_W +: DATA_W];

  // One-hot accept to the winner, only while idle.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win] = 1'b1;
  end

  // Transfer sequencer; all bus and response outputs are registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_write   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_owner <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_write <= w_write;
            busy    <= 1'b1;
            PSEL    <= 1'b1;
            PWRITE  <= w_write;
            // Word-aligned bus address; the slave only decodes the word index.
            PADDR   <= {w_addr[ADDR_W-1:2], 2'b00};
            PWDATA  <= w_wdata;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          PWRITE  <= 1'b0;
          PADDR   <= '0;
          PWDATA  <= '0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          // PRDATA now holds what the slave registered on the ACCESS edge.
          if (!r_write) rsp_rdata <= PRDATA;
          rsp_valid[r_owner] <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
